// File: rtl/i2c_eeprom_slave_if.sv
// I2C pin bundle between a bus master and the EEPROM responder.
// The master owns scl and the resolved sda level; the responder only returns an open-drain pull-down enable.
interface i2c_eeprom_slave_if;
  logic scl;
  logic sda_in;
  logic sda_oe;

  modport master (output scl, output sda_in, input sda_oe);
  modport slave  (input scl, input sda_in, output sda_oe);
endinterface

// File: rtl/i2c_eeprom_slave.sv
// I2C responder modelling a 128x8 EEPROM: oversampled scl/sda, START/STOP detection, command decode, byte write/read.
// Optional macro SEQ_ADDR_INC_EN: auto-increment the address after each committed write or ACKed read byte.
module i2c_eeprom_slave #(
  parameter int unsigned SYNC_STAGES = 2,
  parameter logic [7:0]  MEM_INIT    = 8'hFF
) (
  input  logic                clk,
  input  logic                rst,
  i2c_eeprom_slave_if.slave   bus,
  output logic                busy,
  output logic                wr_stb,
  output logic [6:0]          wr_addr,
  output logic [7:0]          wr_data,
  output logic                done,
  output logic                nack_seen
);

  localparam int unsigned AW    = 7;
  localparam int unsigned DW    = 8;
  localparam int unsigned DEPTH = 128;
  localparam int unsigned CW    = 4;

`ifdef SEQ_ADDR_INC_EN
  localparam bit SEQ_INC = 1'b1;
`else
  localparam bit SEQ_INC = 1'b0;
`endif

  typedef enum logic [2:0] {
    S_IDLE, S_CMD, S_CMD_ACK, S_WDATA, S_WDATA_ACK, S_RDATA, S_RDATA_ACK, S_WAIT_STOP
  } state_t;

  state_t r_state, w_state_nxt;

  logic [SYNC_STAGES-1:0] r_scl_sync, r_sda_sync;
  logic r_scl_d, r_sda_d;
  logic w_scl, w_sda, w_rise, w_fall, w_start, w_stop;

  logic [DW-1:0] r_mem [DEPTH];
  logic [DW-1:0] w_mem_rd, w_byte;
  logic          w_mem_we;

  logic [DW-1:0] r_shift, w_shift_nxt;
  logic [CW-1:0] r_cnt, w_cnt_nxt;
  logic [AW-1:0] r_addr, w_addr_nxt;
  logic          r_rw, w_rw_nxt;
  logic          r_ack_drv, w_ack_drv_nxt;
  logic          r_wr_once, w_wr_once_nxt;
  logic          r_seen, w_seen_nxt;
  logic          r_oe, w_oe_nxt;
  logic          r_busy, w_busy_nxt;
  logic          r_nack, w_nack_nxt;
  logic          r_wr_stb, w_wr_stb_nxt;
  logic [AW-1:0] r_wr_addr, w_wr_addr_nxt;
  logic [DW-1:0] r_wr_data, w_wr_data_nxt;
  logic          r_done, w_done_nxt;
  logic          w_wr_ok;

  // Synchronizer chain plus one delayed copy for edge detection; idle bus level is high.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      r_scl_sync <= '1;
      r_sda_sync <= '1;
      r_scl_d    <= 1'b1;
      r_sda_d    <= 1'b1;
    end else begin
      r_scl_sync <= {r_scl_sync[SYNC_STAGES-2:0], bus.scl};
      r_sda_sync <= {r_sda_sync[SYNC_STAGES-2:0], bus.sda_in};
      r_scl_d    <= r_scl_sync[SYNC_STAGES-1];
      r_sda_d    <= r_sda_sync[SYNC_STAGES-1];
    end
  end

  assign w_scl   = r_scl_sync[SYNC_STAGES-1];
  assign w_sda   = r_sda_sync[SYNC_STAGES-1];
  assign w_rise  = w_scl & ~r_scl_d;
  assign w_fall  = ~w_scl & r_scl_d;
  assign w_start = w_scl & r_scl_d & r_sda_d & ~w_sda;
  assign w_stop  = w_scl & r_scl_d & ~r_sda_d & w_sda;

  assign w_byte   = {r_shift[DW-2:0], w_sda};
  assign w_mem_rd = r_mem[r_addr];
  // Without auto-increment only the first data byte of a write is accepted.
  assign w_wr_ok  = SEQ_INC | ~r_wr_once;

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      for (int i = 0; i < int'(DEPTH); i++) r_mem[i] <= MEM_INIT;
    end else if (w_mem_we) begin
      r_mem[r_addr] <= w_byte;
    end
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) r_state <= S_IDLE;
    else      r_state <= w_state_nxt;
  end

  // Next-state logic; bus conditions outrank any scl edge seen in the same cycle.
  always_comb begin
    w_state_nxt = r_state;
    if (w_stop) begin
      w_state_nxt = S_IDLE;
    end else if (w_start) begin
      w_state_nxt = S_CMD;
    end else begin
      case (r_state)
        S_CMD:       if (w_rise && r_cnt == CW'(7)) w_state_nxt = S_CMD_ACK;
        S_CMD_ACK:   if (w_fall && r_ack_drv) w_state_nxt = r_rw ? S_RDATA : S_WDATA;
        S_WDATA:     if (w_rise && r_cnt == CW'(7)) w_state_nxt = w_wr_ok ? S_WDATA_ACK : S_WAIT_STOP;
        S_WDATA_ACK: if (w_fall && r_ack_drv) w_state_nxt = S_WDATA;
        S_RDATA:     if (w_fall && r_cnt == CW'(8)) w_state_nxt = S_RDATA_ACK;
        S_RDATA_ACK: begin
          if (w_rise && w_sda)            w_state_nxt = S_WAIT_STOP;
          else if (w_fall && r_ack_drv)   w_state_nxt = S_RDATA;
        end
        default: w_state_nxt = r_state;
      endcase
    end
  end

  // Datapath and output next values.
  always_comb begin
    w_shift_nxt   = r_shift;
    w_cnt_nxt     = r_cnt;
    w_addr_nxt    = r_addr;
    w_rw_nxt      = r_rw;
    w_ack_drv_nxt = r_ack_drv;
    w_wr_once_nxt = r_wr_once;
    w_seen_nxt    = r_seen;
    w_oe_nxt      = r_oe;
    w_busy_nxt    = r_busy;
    w_nack_nxt    = r_nack;
    w_wr_stb_nxt  = 1'b0;
    w_wr_addr_nxt = r_wr_addr;
    w_wr_data_nxt = r_wr_data;
    w_done_nxt    = 1'b0;
    w_mem_we      = 1'b0;

    if (w_stop) begin
      w_oe_nxt   = 1'b0;
      w_busy_nxt = 1'b0;
      w_done_nxt = r_seen;
    end else if (w_start) begin
      w_cnt_nxt     = '0;
      w_busy_nxt    = 1'b1;
      w_nack_nxt    = 1'b0;
      w_seen_nxt    = 1'b0;
      w_wr_once_nxt = 1'b0;
      w_ack_drv_nxt = 1'b0;
    end else begin
      case (r_state)
        S_CMD: begin
          if (w_rise) begin
            w_shift_nxt = w_byte;
            w_cnt_nxt   = r_cnt + CW'(1);
            if (r_cnt == CW'(7)) begin
              w_addr_nxt    = r_shift[AW-1:0];
              w_rw_nxt      = w_sda;
              w_cnt_nxt     = '0;
              w_ack_drv_nxt = 1'b0;
            end
          end else if (w_fall) begin
            w_oe_nxt = 1'b0;
          end
        end
        // ACK spans exactly one scl low period; a read then drives its first bit on the release edge.
        S_CMD_ACK, S_WDATA_ACK: begin
          if (w_fall) begin
            if (!r_ack_drv) begin
              w_oe_nxt      = 1'b1;
              w_ack_drv_nxt = 1'b1;
            end else begin
              w_ack_drv_nxt = 1'b0;
              w_cnt_nxt     = '0;
              if (r_state == S_CMD_ACK && r_rw) begin
                w_shift_nxt = w_mem_rd;
                w_oe_nxt    = ~w_mem_rd[DW-1];
              end else begin
                w_oe_nxt = 1'b0;
              end
            end
          end
        end
        S_WDATA: begin
          if (w_rise) begin
            w_shift_nxt = w_byte;
            w_cnt_nxt   = r_cnt + CW'(1);
            if (r_cnt == CW'(7)) begin
              w_cnt_nxt     = '0;
              w_ack_drv_nxt = 1'b0;
              if (w_wr_ok) begin
                w_mem_we      = 1'b1;
                w_wr_stb_nxt  = 1'b1;
                w_wr_addr_nxt = r_addr;
                w_wr_data_nxt = w_byte;
                w_seen_nxt    = 1'b1;
                w_wr_once_nxt = 1'b1;
                if (SEQ_INC) w_addr_nxt = r_addr + AW'(1);
              end
            end
          end
        end
        S_RDATA: begin
          if (w_rise) begin
            w_cnt_nxt = r_cnt + CW'(1);
          end else if (w_fall) begin
            if (r_cnt == CW'(8)) begin
              w_oe_nxt      = 1'b0;
              w_seen_nxt    = 1'b1;
              w_ack_drv_nxt = 1'b0;
            end else begin
              w_oe_nxt = ~r_shift[3'(CW'(7) - r_cnt)];
            end
          end
        end
        S_RDATA_ACK: begin
          if (w_rise) begin
            if (w_sda) begin
              w_nack_nxt = 1'b1;
              w_oe_nxt   = 1'b0;
            end else begin
              w_ack_drv_nxt = 1'b1;
              if (SEQ_INC) w_addr_nxt = r_addr + AW'(1);
            end
          end else if (w_fall && r_ack_drv) begin
            w_ack_drv_nxt = 1'b0;
            w_cnt_nxt     = '0;
            w_shift_nxt   = w_mem_rd;
            w_oe_nxt      = ~w_mem_rd[DW-1];
          end
        end
        default: ;
      endcase
    end
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      r_shift   <= '0;
      r_cnt     <= '0;
      r_addr    <= '0;
      r_rw      <= 1'b0;
      r_ack_drv <= 1'b0;
      r_wr_once <= 1'b0;
      r_seen    <= 1'b0;
      r_oe      <= 1'b0;
      r_busy    <= 1'b0;
      r_nack    <= 1'b0;
      r_wr_stb  <= 1'b0;
      r_wr_addr <= '0;
      r_wr_data <= '0;
      r_done    <= 1'b0;
    end else begin
      r_shift   <= w_shift_nxt;
      r_cnt     <= w_cnt_nxt;
      r_addr    <= w_addr_nxt;
      r_rw      <= w_rw_nxt;
      r_ack_drv <= w_ack_drv_nxt;
      r_wr_once <= w_wr_once_nxt;
      r_seen    <= w_seen_nxt;
      r_oe      <= w_oe_nxt;
      r_busy    <= w_busy_nxt;
      r_nack    <= w_nack_nxt;
      r_wr_stb  <= w_wr_stb_nxt;
      r_wr_addr <= w_wr_addr_nxt;
      r_wr_data <= w_wr_data_nxt;
      r_done    <= w_done_nxt;
    end
  end

  assign bus.sda_oe = r_oe;
  assign busy       = r_busy;
  assign wr_stb     = r_wr_stb;
  assign wr_addr    = r_wr_addr;
  assign wr_data    = r_wr_data;
  assign done       = r_done;
  assign nack_seen  = r_nack;

endmodule

// File: tb/tb_i2c_eeprom_slave.sv
// Scoreboard bench for i2c_eeprom_slave: a bus-master model issues transactions, expectations go into queues,
// a negedge monitor pops and compares on wr_stb, done and every ACK/read byte the master observes.
module tb_i2c_eeprom_slave;

  localparam int Q = 40;
  localparam logic [1:0] K_ACK = 2'd0;
  localparam logic [1:0] K_RD  = 2'd1;

  typedef struct packed {
    logic [1:0] kind;
    logic [7:0] val;
  } obs_t;

  logic clk = 1'b0;
  logic rst;
  logic scl_m, sda_m;
  logic busy, wr_stb, done, nack_seen;
  logic [6:0] wr_addr;
  logic [7:0] wr_data;

  int n_checks = 0;
  int n_errors = 0;

  logic [14:0] exp_wr[$];
  bit          exp_done[$];
  obs_t        exp_obs[$];
  obs_t        act_obs[$];

  i2c_eeprom_slave_if bif();

  assign bif.scl    = scl_m;
  assign bif.sda_in = sda_m & ~bif.sda_oe;

  i2c_eeprom_slave dut (
    .clk       (clk),
    .rst       (rst),
    .bus       (bif),
    .busy      (busy),
    .wr_stb    (wr_stb),
    .wr_addr   (wr_addr),
    .wr_data   (wr_data),
    .done      (done),
    .nack_seen (nack_seen)
  );

  always #5 clk = ~clk;

  initial begin
    #2000000;
    $display("FAIL watchdog: simulation time limit reached, required completion");
    $fatal(1, "watchdog");
  end

  always @(negedge clk) begin : monitor
    logic [14:0] ew;
    obs_t eo, ao;
    if (rst && wr_stb) begin
      n_checks++;
      if (exp_wr.size() == 0) begin
        n_errors++;
        $display("FAIL wr_stb: got addr %h data %h, required no write", wr_addr, wr_data);
      end else begin
        ew = exp_wr.pop_front();
        if ({wr_addr, wr_data} !== ew) begin
          n_errors++;
          $display("FAIL wr_stb: got addr %h data %h, required addr %h data %h",
                   wr_addr, wr_data, ew[14:8], ew[7:0]);
        end
      end
    end
    if (rst && done) begin
      n_checks++;
      if (exp_done.size() == 0) begin
        n_errors++;
        $display("FAIL done: got pulse, required none");
      end else begin
        void'(exp_done.pop_front());
      end
    end
    while (act_obs.size() > 0) begin
      ao = act_obs.pop_front();
      n_checks++;
      if (exp_obs.size() == 0) begin
        n_errors++;
        $display("FAIL obs kind %0d: got %h, required nothing", ao.kind, ao.val);
      end else begin
        eo = exp_obs.pop_front();
        if (ao !== eo) begin
          n_errors++;
          $display("FAIL obs %s: got %h, required %h", (eo.kind == K_ACK) ? "ack" : "rdbyte", ao.val, eo.val);
        end
      end
    end
  end

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_errors++;
      $display("FAIL %s: got %0h, required %0h", name, act, exp);
    end
  endtask

  task automatic i2c_start();
    sda_m = 1'b1; #Q;
    scl_m = 1'b1; #Q;
    sda_m = 1'b0; #Q;
    scl_m = 1'b0; #Q;
  endtask

  task automatic i2c_stop();
    sda_m = 1'b0; #Q;
    scl_m = 1'b1; #Q;
    sda_m = 1'b1; #Q;
  endtask

  task automatic write_bit(input logic b);
    sda_m = b; #Q;
    scl_m = 1'b1; #(2*Q);
    scl_m = 1'b0; #Q;
  endtask

  task automatic read_bit(output logic b);
    sda_m = 1'b1; #Q;
    scl_m = 1'b1; #Q;
    b = bif.sda_in; #Q;
    scl_m = 1'b0; #Q;
  endtask

  task automatic send_byte(input logic [7:0] d);
    logic a;
    for (int i = 7; i >= 0; i--) write_bit(d[i]);
    read_bit(a);
    act_obs.push_back({K_ACK, 7'd0, a});
  endtask

  task automatic recv_byte(input logic ack_bit);
    logic [7:0] d;
    logic b;
    d = '0;
    for (int i = 0; i < 8; i++) begin
      read_bit(b);
      d = {d[6:0], b};
    end
    act_obs.push_back({K_RD, d});
    write_bit(ack_bit);
  endtask

  task automatic expect_ack(input logic a);
    exp_obs.push_back({K_ACK, 7'd0, a});
  endtask

  task automatic expect_rd(input logic [7:0] d);
    exp_obs.push_back({K_RD, d});
  endtask

  task automatic drain(input string name);
    repeat (8) @(negedge clk);
    check({name, " pending writes"}, exp_wr.size(), 0);
    check({name, " pending done"}, exp_done.size(), 0);
    check({name, " pending obs"}, exp_obs.size(), 0);
  endtask

  initial begin
    rst = 1'b0; scl_m = 1'b1; sda_m = 1'b1;
    repeat (3) @(negedge clk);
    check("reset sda_oe", bif.sda_oe, 0);
    check("reset busy", busy, 0);
    check("reset wr_stb", wr_stb, 0);
    check("reset wr_addr", wr_addr, 0);
    check("reset wr_data", wr_data, 0);
    check("reset done", done, 0);
    check("reset nack_seen", nack_seen, 0);
    rst = 1'b1;
    repeat (4) @(negedge clk);

    // Write 0xAA to 0x55
    i2c_start();
    check("busy after start", busy, 1);
    expect_ack(1'b0); send_byte(8'hAA);
    expect_ack(1'b0); exp_wr.push_back({7'h55, 8'hAA}); send_byte(8'hAA);
    exp_done.push_back(1'b1); i2c_stop();
    drain("write55");

    // Read back 0x55 with NACK
    i2c_start();
    expect_ack(1'b0); send_byte(8'hAB);
    expect_rd(8'hAA); recv_byte(1'b1);
    exp_done.push_back(1'b1); i2c_stop();
    drain("read55");
    check("nack_seen after read", nack_seen, 1);
    check("busy after stop", busy, 0);

    // Unwritten location 0x10
    i2c_start();
    expect_ack(1'b0); send_byte(8'h21);
    check("nack_seen cleared by start", nack_seen, 0);
    expect_rd(8'hFF); recv_byte(1'b1);
    exp_done.push_back(1'b1); i2c_stop();
    drain("read10");

    // Partial write aborted by repeated START
    i2c_start();
    expect_ack(1'b0); send_byte(8'h40);
    write_bit(1'b1); write_bit(1'b0); write_bit(1'b1); write_bit(1'b1);
    i2c_start();
    expect_ack(1'b0); send_byte(8'h41);
    expect_rd(8'hFF); recv_byte(1'b1);
    exp_done.push_back(1'b1); i2c_stop();
    drain("rstart20");

    // Asynchronous reset while ACK is driven
    i2c_start();
    for (int i = 7; i >= 0; i--) write_bit(i[0] ? 1'b1 : 1'b0);
    check("ack driven before reset", bif.sda_oe, 1);
    #2 rst = 1'b0;
    #1;
    check("sda_oe in reset", bif.sda_oe, 0);
    check("busy in reset", busy, 0);
    scl_m = 1'b1; sda_m = 1'b1;
    repeat (2) @(negedge clk);
    rst = 1'b1;
    repeat (4) @(negedge clk);
    i2c_start();
    expect_ack(1'b0); send_byte(8'hAB);
    expect_rd(8'hFF); recv_byte(1'b1);
    exp_done.push_back(1'b1); i2c_stop();
    drain("read55 after reset");

    // Two-byte write from 0x7F
    i2c_start();
    expect_ack(1'b0); send_byte(8'hFE);
    expect_ack(1'b0); exp_wr.push_back({7'h7F, 8'h11}); send_byte(8'h11);
`ifdef SEQ_ADDR_INC_EN
    expect_ack(1'b0); exp_wr.push_back({7'h00, 8'h22});
`else
    expect_ack(1'b1);
`endif
    send_byte(8'h22);
    exp_done.push_back(1'b1); i2c_stop();
    drain("write7F");

    // Two-byte read from 0x7F
    i2c_start();
    expect_ack(1'b0); send_byte(8'hFF);
    expect_rd(8'h11); recv_byte(1'b0);
`ifdef SEQ_ADDR_INC_EN
    expect_rd(8'h22);
`else
    expect_rd(8'h11);
`endif
    recv_byte(1'b1);
    exp_done.push_back(1'b1); i2c_stop();
    drain("read7F");
    check("nack_seen after burst", nack_seen, 1);

    $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
    $finish;
  end

endmodule
